uart_frame_parser: RTL and testbench

Byte-level frame decoder directly downstream of the UART receiver. It consumes one received byte per `rx_valid` strobe and recognises frames of the form SOF, LEN, payload, checksum. Each frame is buffered and verified before release. Validated payloads stream out on a valid/ready interface to the command logic; malformed, stalled or overrun frames are discarded and reported on an error strobe.

---
 rtl/uart_frame_parser.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: byte-level frame decoder behind the UART receiver.
// Frames are SOF, LEN, LEN payload bytes, checksum (XOR of LEN and payload).
// A frame is buffered, verified, then streamed out on a valid/ready port.
// Malformed, stalled or overrun frames are dropped and reported on frame_err.
module uart_frame_parser #(
   parameter int unsigned MAX_LEN        = 16,
   parameter logic [7:0]  SOF_BYTE       = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 4340
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int unsigned IDX_W  = $clog2(MAX_LEN + 1);
   localparam int unsigned ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned CNT_W  = 16;

   localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_CHK = 2'd0;
   localparam logic [1:0] ERR_LEN = 2'd1;
   localparam logic [1:0] ERR_TMO = 2'd2;
   localparam logic [1:0] ERR_OVR = 2'd3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GET_LEN = 3'd1,
      GET_PAY = 3'd2,
      GET_CHK = 3'd3,
      SEND    = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   len_q, len_d;
   logic [IDX_W-1:0]   wr_q, wr_d;
   logic [IDX_W-1:0]   rd_q, rd_d;
   logic [7:0]         acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [7:0]         out_data_d;
   logic               out_valid_d;
   logic               out_last_d;
   logic               frame_ok_d;
   logic               frame_err_d;
   logic [1:0]         err_code_d;
   logic               busy_d;

   logic               buf_we;
   logic [7:0]         mem [MAX_LEN];

   logic [IDX_W-1:0]   wr_next;
   logic [IDX_W-1:0]   rd_next;
   logic [IDX_W-1:0]   len_last;
   logic [ADDR_W-1:0]  wr_addr;
   logic [ADDR_W-1:0]  rd_addr;
   logic [ADDR_W-1:0]  rd_next_addr;
   logic               in_get;

   assign wr_next      = wr_q + IDX_W'(1);
   assign rd_next      = rd_q + IDX_W'(1);
   assign len_last     = len_q - IDX_W'(1);
   assign wr_addr      = ADDR_W'(wr_q);
   assign rd_addr      = ADDR_W'(rd_q);
   assign rd_next_addr = ADDR_W'(rd_next);
   assign in_get       = (state_q == GET_LEN) || (state_q == GET_PAY) || (state_q == GET_CHK);

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data;
      out_valid_d = out_valid;
      out_last_d  = out_last;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code;
      buf_we      = 1'b0;

      // Inter-byte watchdog; a byte in the limit cycle takes priority
      if (in_get) begin
         if (rx_valid) begin
            cnt_d = '0;
         end else if (cnt_q == TMO_LAST) begin
            cnt_d       = '0;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
            state_d     = IDLE;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end

      case (state_q)
         IDLE: begin
            if (rx_valid && (rx_data == SOF_BYTE)) begin
               state_d = GET_LEN;
            end
         end

         GET_LEN: begin
            if (rx_valid) begin
               if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_LEN;
                  state_d     = IDLE;
               end else begin
                  len_d   = IDX_W'(rx_data);
                  wr_d    = '0;
                  acc_d   = rx_data;
                  state_d = GET_PAY;
               end
            end
         end

         GET_PAY: begin
            if (rx_valid) begin
               buf_we = 1'b1;
               wr_d   = wr_next;
               acc_d  = acc_q ^ rx_data;
               if (wr_next == len_q) begin
                  state_d = GET_CHK;
               end
            end
         end

         GET_CHK: begin
            if (rx_valid) begin
               if (rx_data == acc_q) begin
                  frame_ok_d = 1'b1;
                  rd_d       = '0;
                  state_d    = SEND;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CHK;
                  state_d     = IDLE;
               end
            end
         end

         SEND: begin
            // The frame is already validated; a new byte here is simply lost
            if (rx_valid) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_OVR;
            end
            if (!out_valid) begin
               out_valid_d = 1'b1;
               out_data_d  = mem[rd_addr];
               out_last_d  = (rd_q == len_last);
            end else if (out_ready) begin
               if (out_last) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = IDLE;
               end else begin
                  rd_d       = rd_next;
                  out_data_d = mem[rd_next_addr];
                  out_last_d = (rd_next == len_last);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, indices, accumulator, watchdog and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         out_data  <= out_data_d;
         out_valid <= out_valid_d;
         out_last  <= out_last_d;
         frame_ok  <= frame_ok_d;
         frame_err <= frame_err_d;
         err_code  <= err_code_d;
         busy      <= busy_d;
      end
   end

   // Payload buffer; contents need no reset
   always_ff @(posedge clk) begin
      if (buf_we) begin
         mem[wr_addr] <= rx_data;
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed protocol cases followed
// by randomized frames scored against a queue-based frame model.
module tb_uart_frame_parser;

   localparam int unsigned MAX_LEN = 16;
   localparam int unsigned TMO     = 40;

   typedef logic [7:0] byte_q_t[$];

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   int tests = 0;
   int fails = 0;
   bit rand_ready = 0;

   logic [8:0] got_q[$];
   logic [1:0] err_q[$];
   int         ok_seen = 0;
   bit         prev_stall = 0;
   logic [7:0] prev_data;
   logic       prev_last;

   uart_frame_parser #(
      .MAX_LEN       (MAX_LEN),
      .SOF_BYTE      (8'hA5),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last),
      .frame_ok (frame_ok),
      .frame_err(frame_err),
      .err_code (err_code),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; inputs change just after the edge
   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_bytes(input byte_q_t bytes, input int max_gap);
      for (int i = 0; i < bytes.size(); i++) begin
         rx_data  = bytes[i];
         rx_valid = 1'b1;
         step();
         rx_valid = 1'b0;
         if (i != bytes.size() - 1) repeat ($urandom_range(0, max_gap)) step();
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         step();
         n++;
      end
      check("idle_wait", 32'(busy), 0);
   endtask

   // Output monitor: handshakes, pulses, and hold-while-stalled rule
   always @(negedge clk) begin
      if (rst) begin
         if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(prev_data));
            check("hold_last", 32'(out_last), 32'(prev_last));
         end
         if (out_valid && out_ready) got_q.push_back({out_last, out_data});
         if (frame_ok) ok_seen++;
         if (frame_err) err_q.push_back(err_code);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end else begin
         prev_stall = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t    bq;
      byte_q_t    pay;
      logic [8:0] exp_q[$];
      logic [1:0] exp_err[$];
      int         exp_ok;
      bit         seen;
      logic [7:0] b;
      logic [7:0] chk;
      int         len;
      int         kind;
      int         n;

      rst       = 1'b0;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) step();

      // Reset values
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_frame_ok", 32'(frame_ok), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_err_code", 32'(err_code), 0);
      rst = 1'b1;
      step();

      // Good frame, out_ready high: 1 byte/cycle
      out_ready = 1'b1;
      bq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      send_bytes(bq, 0);
      check("good_frame_ok", 32'(frame_ok), 1);
      check("good_no_valid_yet", 32'(out_valid), 0);
      step();
      check("good_b0", {22'd0, out_valid, out_last, out_data}, 'h211);
      check("good_ok_pulse_once", 32'(frame_ok), 0);
      step();
      check("good_b1", {22'd0, out_valid, out_last, out_data}, 'h222);
      step();
      check("good_b2", {22'd0, out_valid, out_last, out_data}, 'h333);
      step();
      check("good_done_valid", 32'(out_valid), 0);
      check("good_done_busy", 32'(busy), 0);

      // Bad checksum (expected 02^10^20 = 32), then a good one-byte frame
      bq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h04};
      send_bytes(bq, 0);
      check("badchk_err", 32'(frame_err), 1);
      check("badchk_code", 32'(err_code), 0);
      check("badchk_busy", 32'(busy), 0);
      step();
      check("badchk_no_valid", 32'(out_valid), 0);
      check("badchk_err_pulse", 32'(frame_err), 0);
      bq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
      send_bytes(bq, 0);
      check("one_ok", 32'(frame_ok), 1);
      step();
      check("one_b0", {22'd0, out_valid, out_last, out_data}, 'h37E);
      step();
      check("one_done", 32'(out_valid), 0);

      // Bad lengths: zero and MAX_LEN+1
      bq = '{8'hA5, 8'h00};
      send_bytes(bq, 0);
      check("len0_err", {29'd0, frame_err, err_code}, 'h5);
      bq = '{8'hA5, 8'h11};
      send_bytes(bq, 0);
      check("len17_err", {29'd0, frame_err, err_code}, 'h5);
      bq = '{8'h33};
      send_bytes(bq, 0);
      check("stray_no_err", 32'(frame_err), 0);
      check("stray_idle", 32'(busy), 0);
      check("err_code_holds", 32'(err_code), 1);

      // Timeout: error exactly TMO cycles after the last strobe, plus one
      bq = '{8'hA5, 8'h02, 8'h10};
      send_bytes(bq, 0);
      seen = 0;
      repeat (TMO - 1) begin
         step();
         if (frame_err) seen = 1;
      end
      check("tmo_not_early", 32'(seen), 0);
      step();
      check("tmo_err", {29'd0, frame_err, err_code}, 'h6);
      check("tmo_idle", 32'(busy), 0);

      // A byte landing on the limit cycle keeps the frame alive
      bq = '{8'hA5, 8'h02, 8'h10};
      send_bytes(bq, 0);
      repeat (TMO - 1) step();
      bq = '{8'h20};
      send_bytes(bq, 0);
      check("limit_no_err", 32'(frame_err), 0);
      check("limit_busy", 32'(busy), 1);
      repeat (TMO - 1) step();
      bq = '{8'h32};
      send_bytes(bq, 0);
      check("limit_ok", 32'(frame_ok), 1);
      step();
      check("limit_b0", {22'd0, out_valid, out_last, out_data}, 'h210);
      step();
      check("limit_b1", {22'd0, out_valid, out_last, out_data}, 'h320);
      step();
      check("limit_done", 32'(busy), 0);

      // Backpressure plus overrun; checksum 02^AB^CD = 64
      out_ready = 1'b0;
      bq = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64};
      send_bytes(bq, 0);
      check("bp_ok", 32'(frame_ok), 1);
      step();
      check("bp_b0", {22'd0, out_valid, out_last, out_data}, 'h2AB);
      step();
      step();
      check("bp_hold", {22'd0, out_valid, out_last, out_data}, 'h2AB);
      bq = '{8'hA5};
      send_bytes(bq, 0);
      check("ovr_err", {29'd0, frame_err, err_code}, 'h7);
      check("ovr_hold", {22'd0, out_valid, out_last, out_data}, 'h2AB);
      step();
      out_ready = 1'b1;
      step();
      check("bp_b1", {22'd0, out_valid, out_last, out_data}, 'h3CD);
      step();
      check("bp_done_valid", 32'(out_valid), 0);
      check("bp_sof_not_recovered", 32'(busy), 0);

      // Asynchronous reset in mid-payload
      bq = '{8'hA5, 8'h03, 8'h11};
      send_bytes(bq, 0);
      check("mid_busy", 32'(busy), 1);
      rst = 1'b0;
      #1;
      check("mid_rst_outs", {18'd0, busy, out_valid, out_last, frame_ok, frame_err, err_code, out_data}, 0);
      step();
      rst = 1'b1;
      step();
      check("post_rst_quiet", {29'd0, frame_ok, frame_err, busy}, 0);
      bq = '{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h9B};
      send_bytes(bq, 0);
      check("post_rst_ok", 32'(frame_ok), 1);
      step();
      check("post_rst_b0", {22'd0, out_valid, out_last, out_data}, 'h25A);
      step();
      check("post_rst_b1", {22'd0, out_valid, out_last, out_data}, 'h3C3);
      step();

      // Randomized frames against the frame-level model
      got_q.delete();
      err_q.delete();
      ok_seen    = 0;
      exp_ok     = 0;
      rand_ready = 1;
      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            bq = '{b};
            send_bytes(bq, 0);
         end
         kind = int'($urandom_range(0, 9));
         len  = int'($urandom_range(1, MAX_LEN));
         pay.delete();
         chk = 8'(len);
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            pay.push_back(b);
            chk = chk ^ b;
         end
         bq = '{8'hA5};
         if (kind >= 8) begin
            if ($urandom_range(0, 1) == 0) bq.push_back(8'h00);
            else bq.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
            exp_err.push_back(2'd1);
         end else begin
            bq.push_back(8'(len));
            foreach (pay[i]) bq.push_back(pay[i]);
            if (kind >= 6) begin
               bq.push_back(chk ^ 8'($urandom_range(1, 255)));
               exp_err.push_back(2'd0);
            end else begin
               bq.push_back(chk);
               foreach (pay[i]) exp_q.push_back({(i == len - 1), pay[i]});
               exp_ok++;
            end
         end
         send_bytes(bq, 3);
         wait_idle(800);
      end
      rand_ready = 0;
      out_ready  = 1'b1;
      repeat (3) step();

      check("rand_ok_count", 32'(ok_seen), 32'(exp_ok));
      check("rand_byte_count", 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check("rand_byte", 32'(got_q[i]), 32'(exp_q[i]));
      check("rand_err_count", 32'(err_q.size()), 32'(exp_err.size()));
      n = (err_q.size() < exp_err.size()) ? err_q.size() : exp_err.size();
      for (int i = 0; i < n; i++) check("rand_err_code", 32'(err_q[i]), 32'(exp_err[i]));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
